width_construct: RTL

- Reassembles a stream of narrow DSIZE-bit pieces into one wide DSIZE*NSIZE-bit word. It is the receive-side counterpart of the width destructor.
- Packing is MSB-first: the first piece accepted lands in the top lane.
- An early wr_last flushes a partial word, zero-padded, with a count of valid pieces.
- Used ahead of wide datapaths (I2C byte assembly, register loads). Single clock domain.

---
 rtl/width_construct_if.sv | 33 +++
 rtl/width_construct.sv | 82 ++++++++
 2 files changed

// File: rtl/width_construct_if.sv
// Bus bundle for width_construct: narrow write stream in, wide word stream out.
// Both sides use valid/ready. A transfer happens on a rising clock edge where
// valid and ready are both high. A source holds its data and valid until that
// transfer. A source never lowers valid before the transfer. Ready may change
// freely and does not depend on valid.
interface width_construct_if #(
  parameter int DSIZE = 1,
  parameter int NSIZE = 8
);
  localparam int CSIZE = $clog2(NSIZE + 1);

  logic [DSIZE-1:0]       wr_data;
  logic                   wr_vld;
  logic                   wr_ready;
  logic                   wr_last;
  logic [DSIZE*NSIZE-1:0] rd_data;
  logic                   rd_vld;
  logic                   rd_ready;
  logic                   rd_last;
  logic [CSIZE-1:0]       rd_cnt;

  // Upstream producer and downstream consumer, seen from outside the block
  modport master (
    output wr_data, wr_vld, wr_last, rd_ready,
    input  wr_ready, rd_data, rd_vld, rd_last, rd_cnt
  );

  // The width_construct block itself
  modport slave (
    input  wr_data, wr_vld, wr_last, rd_ready,
    output wr_ready, rd_data, rd_vld, rd_last, rd_cnt
  );
endinterface

// File: rtl/width_construct.sv
// width_construct: packs DSIZE-bit pieces MSB-first into DSIZE*NSIZE-bit words.
// An early wr_last flushes a zero-padded partial word. rd_cnt reports how many
// pieces are valid in that word. A single output register stage gives
// back-to-back words with no bubble while the consumer keeps rd_ready high.
module width_construct #(
  parameter int DSIZE = 1,
  parameter int NSIZE = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  width_construct_if.slave bus
);
  localparam int CSIZE = $clog2(NSIZE + 1);
  localparam int WSIZE = DSIZE * NSIZE;
  localparam logic [CSIZE-1:0] LAST_PT = CSIZE'(NSIZE - 1);

  logic [WSIZE-1:0] acc_q;
  logic [CSIZE-1:0] point_q;
  logic [WSIZE-1:0] rd_data_q;
  logic [CSIZE-1:0] rd_cnt_q;
  logic             rd_vld_q;
  logic             rd_last_q;

  logic             wr_ready;
  logic             wr_acc;
  logic             rd_acc;
  logic             completion;
  logic [WSIZE-1:0] merged;

  // The input side may advance whenever the output slot is free or is being emptied this cycle
  assign wr_ready   = ~rd_vld_q | bus.rd_ready;
  assign wr_acc     = bus.wr_vld & wr_ready;
  assign rd_acc     = rd_vld_q & bus.rd_ready;
  assign completion = wr_acc & ((point_q == LAST_PT) | bus.wr_last);

  // Accumulator with the incoming piece dropped into the lane selected by point_q (lane 0 = MSB)
  always_comb begin
    merged = acc_q;
    for (int i = 0; i < NSIZE; i++) begin
      if (point_q == CSIZE'(i)) begin
        merged[DSIZE*(NSIZE-i)-1 -: DSIZE] = bus.wr_data;
      end
    end
  end

  // Partial-word accumulator and lane pointer; cleared whenever a word is handed off
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      point_q <= '0;
    end else if (completion) begin
      acc_q   <= '0;
      point_q <= '0;
    end else if (wr_acc) begin
      acc_q   <= merged;
      point_q <= point_q + 1'b1;
    end
  end

  // Output word register; a new word may replace the old one in the same cycle it is consumed
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_cnt_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else if (completion) begin
      rd_data_q <= merged;
      rd_cnt_q  <= point_q + 1'b1;
      rd_vld_q  <= 1'b1;
      rd_last_q <= bus.wr_last;
    end else if (rd_acc) begin
      rd_vld_q  <= 1'b0;
    end
  end

  assign bus.wr_ready = wr_ready;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_cnt   = rd_cnt_q;
  assign bus.rd_vld   = rd_vld_q;
  assign bus.rd_last  = rd_last_q;
endmodule
